multiword_add_sched: RTL and testbench

MULTIWORD_ADD_SCHED -- requirements
Module: multiword_add_sched

---
 rtl/multiword_add_sched.sv | 144 ++++++++++++++
 tb/tb_multiword_add_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sched.sv
// multiword_add_sched: two requesters share one 8-bit ripple-carry slice.
// Each accepted W-bit add is computed one byte per cycle, least significant
// byte first. Grant is round-robin. A result is held until the consumer takes it.

// One-bit full adder cell; eight of these form the shared byte slice.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module multiword_add_sched #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [8*WORDS-1:0]   req0_a,
  input  logic [8*WORDS-1:0]   req0_b,
  input  logic                 req0_cin,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [8*WORDS-1:0]   req1_a,
  input  logic [8*WORDS-1:0]   req1_b,
  input  logic                 req1_cin,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [8*WORDS:0]     res_sum,
  output logic                 res_id
);
  localparam int W  = 8 * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic          r_ptr;
  logic          r_carry;
  logic          r_id;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum_lo;
  logic          r_cout;

  logic          w_idle;
  logic          w_gnt;
  logic          w_accept;
  logic [CW+2:0] w_lo;
  logic [7:0]    w_sa;
  logic [7:0]    w_sb;
  logic [7:0]    w_ss;
  logic [8:0]    w_c;

  // Arbitration and ready: a single valid requester wins outright, a tie goes to r_ptr.
  // NOTE: every output of this block is assigned on every path, so no latch is inferred.
  always_comb begin
    w_idle     = (r_state == S_IDLE);
    w_gnt      = (req0_valid && req1_valid) ? r_ptr : req1_valid;
    req0_ready = w_idle && req0_valid && !w_gnt;
    req1_ready = w_idle && req1_valid &&  w_gnt;
    w_accept   = req0_ready || req1_ready;
  end

  // Byte selection for the current slice: bit offset is cnt*8.
  assign w_lo = {r_cnt, 3'b000};
  assign w_sa = r_a[w_lo +: 8];
  assign w_sb = r_b[w_lo +: 8];
  assign w_c[0] = r_carry;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slice
      full_adder u_fa (
        .i_a (w_sa[gi]),
        .i_b (w_sb[gi]),
        .i_c (w_c[gi]),
        .o_s (w_ss[gi]),
        .o_c (w_c[gi+1])
      );
    end
  endgenerate

  // Operand capture on acceptance; these are only read in ADD, so they carry no reset.
  // NOTE: datapath-only registers are left unreset; reset covers control and visible outputs.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= w_gnt ? req1_a : req0_a;
      r_b <= w_gnt ? req1_b : req0_b;
    end
  end

  // Control FSM and result accumulation, one byte slice per ADD cycle.
  // NOTE: sequential state uses non-blocking assignment so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= 1'b0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_id     <= 1'b0;
      r_sum_lo <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id    <= w_gnt;
            r_ptr   <= ~w_gnt;
            r_carry <= w_gnt ? req1_cin : req0_cin;
            r_cnt   <= '0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_sum_lo[w_lo +: 8] <= w_ss;
          r_carry             <= w_c[8];
          r_cnt               <= r_cnt + CW'(1);
          if (r_cnt == CW'(WORDS - 1)) begin
            r_cout  <= w_c[8];
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign res_valid = (r_state == S_DONE);
  assign res_sum   = {r_cout, r_sum_lo};
  assign res_id    = r_id;

endmodule

// File: tb/tb_multiword_add_sched.sv
// Bench for multiword_add_sched: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the scheduler.
module tb_multiword_add_sched;
  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_cin;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         res_valid, res_ready, res_id;
  logic [W:0]   res_sum;

  always #5 clk = ~clk;

  multiword_add_sched #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_id     (res_id)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Handshakes seen at each rising edge, read by the driver just after it.
  logic acc0 = 1'b0, acc1 = 1'b0;
  always @(posedge clk) begin
    acc0 <= req0_valid && req0_ready && rst_n;
    acc1 <= req1_valid && req1_ready && rst_n;
  end

  // ---------------- transaction-level reference model ----------------
  typedef enum {M_IDLE, M_BUSY, M_DONE} mst_t;
  mst_t       m_st    = M_IDLE;
  bit         m_known = 1'b0;
  int         m_left  = 0;
  logic       m_ptr   = 1'b0;
  logic       m_id    = 1'b0;
  logic [W:0] m_sum   = '0;

  // Compare on the falling edge (inputs are stable here), then advance the model one cycle.
  always @(negedge clk) begin
    logic g, e0, e1;
    g  = (req0_valid && req1_valid) ? m_ptr : req1_valid;
    e0 = (m_st == M_IDLE) && req0_valid && !g;
    e1 = (m_st == M_IDLE) && req1_valid &&  g;
    if (m_known) begin
      check("req0_ready", req0_ready, e0);
      check("req1_ready", req1_ready, e1);
      check("res_valid",  res_valid,  m_st == M_DONE);
      if (m_st == M_DONE) begin
        check("res_sum", res_sum, m_sum);
        check("res_id",  res_id,  m_id);
      end
    end
    if (!rst_n) begin
      m_st    = M_IDLE;
      m_ptr   = 1'b0;
      m_known = 1'b1;
    end else if (m_known) begin
      case (m_st)
        M_IDLE: if (e0 || e1) begin
          m_sum  = e1 ? ({1'b0, req1_a} + req1_b + req1_cin)
                      : ({1'b0, req0_a} + req0_b + req0_cin);
          m_id   = g;
          m_ptr  = !g;
          m_left = WORDS;
          m_st   = M_BUSY;
        end
        M_BUSY: begin
          m_left--;
          if (m_left == 0) m_st = M_DONE;
        end
        M_DONE: if (res_ready) m_st = M_IDLE;
        default: m_st = M_IDLE;
      endcase
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    if (id == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; end
    else         begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; end
  endtask

  task automatic wait_accept(input int id);
    bit got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = (id == 0) ? acc0 : acc1;
    end
    check("accept_seen", got, 1'b1);
  endtask

  // Waits for res_valid; returns the number of ticks it took.
  task automatic wait_result(output int n);
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    check("result_seen", res_valid, 1'b1);
  endtask

  task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic [W:0] exp_sum);
    int n;
    drive(id, a, b, cin);
    wait_accept(id);
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    wait_result(n);
    check("latency", n + 1, WORDS + 1);
    check("lit_sum", res_sum, exp_sum);
    check("lit_id",  res_id, id);
    if (res_ready) tick();
  endtask

  task automatic drain();
    int n = 0;
    res_ready = 1'b1;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    if (res_valid) tick();
  endtask

  function automatic logic [W-1:0] rnd_word();
    return ($urandom_range(3) == 0) ? {W{1'b1}} : W'($urandom);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int grants[$];
    int n;
    rst_n = 1'b0; res_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    repeat (2) tick();
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_sum",   res_sum,   '0);
    check("rst_res_id",    res_id,    1'b0);
    rst_n = 1'b1;
    tick();

    // Both requesters continuously valid: alternating grants starting at 0.
    drive(0, 32'h1111_1111, 32'h0000_0001, 1'b0);
    drive(1, 32'h2222_2222, 32'h0000_0002, 1'b1);
    for (int k = 0; k < 100 && grants.size() < 4; k++) begin
      tick();
      if (acc0) begin grants.push_back(0); drive(0, rnd_word(), rnd_word(), 1'($urandom)); end
      if (acc1) begin grants.push_back(1); drive(1, rnd_word(), rnd_word(), 1'($urandom)); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();
    check("grant_count", grants.size(), 4);
    for (int i = 0; i < grants.size() && i < 4; i++) check("grant_order", grants[i], i % 2);

    // Directed arithmetic cases.
    do_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0100);
    do_op(1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000);
    do_op(0, 32'h8080_8080, 32'h8080_8080, 1'b0, 33'h1_0101_0100);

    // Back-pressure: result must hold for three stalled cycles.
    res_ready = 1'b0;
    do_op(1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 33'h0_ACF1_3569);
    drive(0, 32'h0000_0005, 32'h0000_0006, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_valid", res_valid, 1'b1);
      check("stall_sum",   res_sum, 33'h0_ACF1_3569);
      check("stall_id",    res_id,  1'b1);
      check("stall_ready0", req0_ready, 1'b0);
    end
    req0_valid = 1'b0;
    res_ready  = 1'b1;
    tick();
    check("release_valid", res_valid, 1'b0);

    // Reset in the ADD cycle with cnt=2 drops the operation and clears the pointer.
    drive(0, 32'hDEAD_BEEF, 32'h0000_0001, 1'b0);
    wait_accept(0);
    req0_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < WORDS + 3; k++) begin
      check("no_pulse_after_reset", res_valid, 1'b0);
      tick();
    end
    drive(0, 32'h0000_0010, 32'h0000_0020, 1'b0);
    drive(1, 32'h0000_0030, 32'h0000_0040, 1'b0);
    n = 0;
    while (!acc0 && !acc1 && n < 20) begin tick(); n++; end
    check("post_reset_grant0", {acc1, acc0}, 2'b01);
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Random traffic with withdrawals, back-pressure and occasional reset.
    for (int c = 0; c < 600; c++) begin
      if (acc0) begin
        if ($urandom_range(1) == 0) req0_valid = 1'b0;
        else drive(0, rnd_word(), rnd_word(), 1'($urandom));
      end else if (!req0_valid) begin
        if ($urandom_range(9) < 4) drive(0, rnd_word(), rnd_word(), 1'($urandom));
      end else if ($urandom_range(19) == 0) req0_valid = 1'b0;
      if (acc1) begin
        if ($urandom_range(1) == 0) req1_valid = 1'b0;
        else drive(1, rnd_word(), rnd_word(), 1'($urandom));
      end else if (!req1_valid) begin
        if ($urandom_range(9) < 4) drive(1, rnd_word(), rnd_word(), 1'($urandom));
      end else if ($urandom_range(19) == 0) req1_valid = 1'b0;
      res_ready = ($urandom_range(2) != 0);
      rst_n     = ($urandom_range(149) != 0);
      tick();
    end
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
